// File: rtl/riscv_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding, grant
// owner encodings and the latency counter width.
package riscv_arb_pkg;

  localparam int ARB_STATE_W = 2;
  localparam int LAT_CNT_W   = 4;

  typedef enum logic [ARB_STATE_W-1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic GRANT_IF   = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/arb_latency_cnt.sv
// Loadable down-counter with a zero flag; times the memory access window.
module arb_latency_cnt
  import riscv_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between fetch and data ports, data first.
// Optional fetch starvation guard: define UNIFIED_MEM_ARB_STARVE_GUARD_EN.
module unified_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fetch_stall,
  output logic                pipe_stall,
  output logic                grant_data
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || STARVE_LIMIT < 1) begin : g_param_check
    $error("unified_mem_arbiter: MEM_LATENCY must be 1..15 and STARVE_LIMIT >= 1");
  end

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              grant_data_q, grant_data_d;
  logic              lat_load, lat_dec, lat_zero;
  logic              grant_dat, grant_fetch, force_fetch;

  assign grant_dat   = (state_q == IDLE) && d_req && !force_fetch;
  assign grant_fetch = (state_q == IDLE) && if_req && !grant_dat;

`ifdef UNIFIED_MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;

  // Counts data grants that overtook a waiting fetch; at the limit fetch wins.
  assign force_fetch = if_req && (starve_q == STARVE_MAX);

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!if_req || grant_fetch) begin
        starve_d = '0;
      end else if (grant_dat && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  arb_latency_cnt u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_data_d = grant_data_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    lat_load     = 1'b0;
    lat_dec      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_dat) begin
          state_d      = DATA;
          addr_d       = d_addr;
          we_d         = d_we;
          be_d         = d_be;
          wdata_d      = d_wdata;
          grant_data_d = GRANT_DATA;
          lat_load     = 1'b1;
        end else if (grant_fetch) begin
          state_d      = FETCH;
          addr_d       = if_addr;
          we_d         = 1'b0;
          be_d         = '0;
          wdata_d      = '0;
          grant_data_d = GRANT_IF;
          lat_load     = 1'b1;
        end
      end
      FETCH, DATA: begin
        if (lat_zero) begin
          state_d = RESP;
          if (state_q == FETCH) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            d_rdata_d = we_q ? '0 : mem_rdata;
            d_done_d  = 1'b1;
          end
        end else begin
          lat_dec = 1'b1;
        end
      end
      RESP: begin
        // Requests are ignored here so the finishing requester cannot be granted twice.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      grant_data_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      grant_data_q <= grant_data_d;
    end
  end

  // A store only strobes in its last cycle, so an aborted store never commits.
  assign mem_en      = (state_q == FETCH) || (state_q == DATA);
  assign mem_we      = (state_q == DATA) && we_q && lat_zero;
  assign mem_be      = be_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_done     = if_done_q;
  assign d_done      = d_done_q;
  assign grant_data  = grant_data_q;
  assign fetch_stall = if_req & ~if_done_q;
  assign pipe_stall  = d_req & ~d_done_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: transaction-level model checked every cycle
// plus directed literal checks; a second MEM_LATENCY=1 instance checks timing.
module tb_unified_mem_arbiter;

  localparam int LAT   = 2;
  localparam int LIMIT = 4;
`ifdef UNIFIED_MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, d_done, mem_en, mem_we, fetch_stall, pipe_stall, grant_data;
  logic [3:0]  mem_be;

  logic        if_req1, d_req1;
  logic [31:0] if_addr1, d_addr1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_done1, d_done1, mem_en1, mem_we1, fetch_stall1, pipe_stall1, grant_data1;
  logic [3:0]  mem_be1;

  logic [31:0] memArr [0:63];
  int compared = 0;
  int mismatched = 0;
  int cycleNo = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleNo <= cycleNo + 1;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fetch_stall(fetch_stall), .pipe_stall(pipe_stall), .grant_data(grant_data)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1),
    .d_req(d_req1), .d_we(1'b0), .d_be(4'h0), .d_addr(d_addr1), .d_wdata(32'h0),
    .d_rdata(d_rdata1), .d_done(d_done1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .fetch_stall(fetch_stall1), .pipe_stall(pipe_stall1), .grant_data(grant_data1)
  );

  assign mem_rdata  = memArr[mem_addr[7:2]];
  assign mem_rdata1 = memArr[mem_addr1[7:2]];

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endfunction

  // Environment memory: preload, then commit byte-enabled writes seen on the strobe.
  initial begin : memEnv
    logic        wePend;
    logic [31:0] wAddr, wData;
    logic [3:0]  wBe;
    for (int i = 0; i < 64; i++) memArr[i] = 32'h0;
    memArr[4]  = 32'h00A00093;
    memArr[16] = 32'h00001234;
    memArr[17] = 32'h0BADF00D;
    for (int i = 0; i < 6; i++) memArr[32+i] = 32'h100 + 32'(i);
    forever begin
      @(negedge clk);
      wePend = mem_en && mem_we;
      wAddr = mem_addr; wData = mem_wdata; wBe = mem_be;
      @(posedge clk);
      if (wePend && rst) begin
        for (int b = 0; b < 4; b++)
          if (wBe[b]) memArr[wAddr[7:2]][8*b +: 8] = wData[8*b +: 8];
      end
    end
  end

  // Posting tables consumed by the requester agents.
  logic [31:0] ifAddrArr [0:15];
  int          ifPostCnt = 0;
  int          ifIdx;
  logic        dWeArr [0:15];
  logic [3:0]  dBeArr [0:15];
  logic [31:0] dAddrArr [0:15];
  logic [31:0] dWdArr [0:15];
  int          dPostCnt = 0;
  int          dIdx;

  initial begin : fetchAgent
    logic sawDone;
    if_req = 1'b0; if_addr = 32'h0; ifIdx = 0;
    forever begin
      @(negedge clk); sawDone = if_done;
      @(posedge clk); #1;
      if (!rst) begin
        if_req = 1'b0; ifIdx = ifPostCnt;
      end else if (if_req && sawDone) begin
        ifIdx++;
        if (ifIdx < ifPostCnt) if_addr = ifAddrArr[ifIdx];
        else if_req = 1'b0;
      end else if (!if_req && ifIdx < ifPostCnt) begin
        if_addr = ifAddrArr[ifIdx]; if_req = 1'b1;
      end
    end
  end

  initial begin : dataAgent
    logic sawDone;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; dIdx = 0;
    forever begin
      @(negedge clk); sawDone = d_done;
      @(posedge clk); #1;
      if (!rst) begin
        d_req = 1'b0; dIdx = dPostCnt;
      end else if ((d_req && sawDone) || (!d_req && dIdx < dPostCnt)) begin
        if (d_req) dIdx++;
        if (dIdx < dPostCnt) begin
          d_we = dWeArr[dIdx]; d_be = dBeArr[dIdx];
          d_addr = dAddrArr[dIdx]; d_wdata = dWdArr[dIdx]; d_req = 1'b1;
        end else begin
          d_req = 1'b0;
        end
      end
    end
  end

  // Event log: raise cycles, done cycles with data, write-strobe cycles.
  int          ifDoneCyc[$], dDoneCyc[$], weCyc[$];
  logic [31:0] ifDoneData[$], dDoneData[$];
  int          ifRaiseCyc = 0, dRaiseCyc = 0;
  logic        prevIfReq = 1'b0, prevDReq = 1'b0;

  always @(negedge clk) begin
    if (if_req && !prevIfReq) ifRaiseCyc = cycleNo;
    if (d_req && !prevDReq) dRaiseCyc = cycleNo;
    prevIfReq = if_req; prevDReq = d_req;
    if (if_done) begin ifDoneCyc.push_back(cycleNo); ifDoneData.push_back(if_rdata); end
    if (d_done) begin dDoneCyc.push_back(cycleNo); dDoneData.push_back(d_rdata); end
    if (mem_we) weCyc.push_back(cycleNo);
  end

  // Transaction model: an access granted in an idle cycle occupies the memory for
  // LAT cycles and reports done in the cycle after; the next idle cycle arbitrates.
  bit          mBusy = 0, mOwnerD = 0, mWe = 0, mGrantD = 0;
  int          mK = 0, mStarve = 0;
  logic [31:0] mAddr = 0, mWdata = 0, mIfRdata = 0, mDRdata = 0;
  logic [3:0]  mBe = 0;

  always @(negedge clk) begin : modelCompare
    logic expEn, expWe, expIfDone, expDDone, forceF;
    if (!rst) begin
      checkOutput("rst.mem_en", 32'(mem_en), 32'd0);
      checkOutput("rst.mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst.if_done", 32'(if_done), 32'd0);
      checkOutput("rst.d_done", 32'(d_done), 32'd0);
      checkOutput("rst.if_rdata", if_rdata, 32'd0);
      checkOutput("rst.d_rdata", d_rdata, 32'd0);
      checkOutput("rst.grant_data", 32'(grant_data), 32'd0);
      checkOutput("rst.mem_addr", mem_addr, 32'd0);
      mBusy = 0; mK = 0; mIfRdata = 0; mDRdata = 0; mGrantD = 0; mStarve = 0;
    end else begin
      expEn     = mBusy && mK >= 1 && mK <= LAT;
      expWe     = expEn && mOwnerD && mWe && mK == LAT;
      expIfDone = mBusy && !mOwnerD && mK == LAT + 1;
      expDDone  = mBusy && mOwnerD && mK == LAT + 1;
      if (expIfDone) mIfRdata = memArr[mAddr[7:2]];
      if (expDDone) mDRdata = mWe ? 32'h0 : memArr[mAddr[7:2]];
      checkOutput("model.mem_en", 32'(mem_en), 32'(expEn));
      checkOutput("model.mem_we", 32'(mem_we), 32'(expWe));
      checkOutput("model.if_done", 32'(if_done), 32'(expIfDone));
      checkOutput("model.d_done", 32'(d_done), 32'(expDDone));
      checkOutput("model.if_rdata", if_rdata, mIfRdata);
      checkOutput("model.d_rdata", d_rdata, mDRdata);
      checkOutput("model.grant_data", 32'(grant_data), 32'(mGrantD));
      checkOutput("model.fetch_stall", 32'(fetch_stall), 32'(if_req && !expIfDone));
      checkOutput("model.pipe_stall", 32'(pipe_stall), 32'(d_req && !expDDone));
      if (expEn) checkOutput("model.mem_addr", mem_addr, mAddr);
      if (expEn && mOwnerD) begin
        checkOutput("model.mem_be", 32'(mem_be), 32'(mBe));
        checkOutput("model.mem_wdata", mem_wdata, mWdata);
      end
      if (mBusy) begin
        if (mK == LAT + 1) mBusy = 0;
        else mK++;
      end else begin
        if (GUARD && !if_req) mStarve = 0;
        forceF = GUARD && if_req && mStarve >= LIMIT;
        if (d_req && !forceF) begin
          mBusy = 1; mK = 1; mOwnerD = 1; mGrantD = 1;
          mAddr = d_addr; mWe = d_we; mBe = d_be; mWdata = d_wdata;
          if (GUARD && if_req && mStarve < LIMIT) mStarve++;
        end else if (if_req) begin
          mBusy = 1; mK = 1; mOwnerD = 0; mGrantD = 0; mAddr = if_addr; mWe = 0;
          mStarve = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input bit isFetch, input bit we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (isFetch) begin
      ifAddrArr[ifPostCnt] = addr; ifPostCnt++;
    end else begin
      dWeArr[dPostCnt] = we; dBeArr[dPostCnt] = be;
      dAddrArr[dPostCnt] = addr; dWdArr[dPostCnt] = wdata; dPostCnt++;
    end
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (n < 300 && !(ifIdx == ifPostCnt && dIdx == dPostCnt && !if_req && !d_req)) begin
      @(negedge clk); n++;
    end
    checkOutput({tag, "_timeout"}, 32'(n >= 300), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : mainSeq
    int baseD, baseF, baseW, startC, got, cnt;
    int doneC [0:1];
    logic [31:0] doneD [0:1];
    bit found;
    rst = 1'b0;
    if_req1 = 1'b0; if_addr1 = 32'h0; d_req1 = 1'b0; d_addr1 = 32'h0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] latency-1 instance");
    @(posedge clk); #1; if_addr1 = 32'h10; if_req1 = 1'b1; startC = cycleNo; found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (if_done1) found = 1;
    end
    checkOutput("lat1_fetch_seen", 32'(found), 32'd1);
    checkOutput("lat1_fetch_latency", 32'(cycleNo - startC), 32'd2);
    checkOutput("lat1_if_rdata", if_rdata1, 32'h00A00093);
    @(posedge clk); #1 if_req1 = 1'b0;
    @(posedge clk); #1; d_addr1 = 32'h40; d_req1 = 1'b1; startC = cycleNo; got = 0;
    for (int n = 0; n < 30 && got < 2; n++) begin
      @(negedge clk);
      if (d_done1) begin
        doneC[got] = cycleNo; doneD[got] = d_rdata1; got++;
        @(posedge clk); #1;
        if (got == 1) d_addr1 = 32'h44;
        else d_req1 = 1'b0;
      end
    end
    checkOutput("lat1_load_count", 32'(got), 32'd2);
    checkOutput("lat1_load_latency", 32'(doneC[0] - startC), 32'd2);
    checkOutput("lat1_throughput", 32'(doneC[1] - doneC[0]), 32'd3);
    checkOutput("lat1_d_rdata0", doneD[0], 32'h00001234);
    checkOutput("lat1_d_rdata1", doneD[1], 32'h0BADF00D);

    $display("[TB] fetch only");
    baseF = ifDoneCyc.size();
    applyStimulus(1, 0, 4'h0, 32'h10, 32'h0);
    waitIdle("fetch_only");
    checkOutput("fetch_done_cycle", 32'(ifDoneCyc[baseF] - ifRaiseCyc), 32'd3);
    checkOutput("fetch_rdata", ifDoneData[baseF], 32'h00A00093);
    checkOutput("fetch_stall_after", 32'(fetch_stall), 32'd0);

    $display("[TB] simultaneous load and fetch");
    baseF = ifDoneCyc.size(); baseD = dDoneCyc.size();
    applyStimulus(0, 0, 4'h0, 32'h40, 32'h0);
    applyStimulus(1, 0, 4'h0, 32'h10, 32'h0);
    waitIdle("simultaneous");
    checkOutput("simul_d_done", 32'(dDoneCyc[baseD] - dRaiseCyc), 32'd3);
    checkOutput("simul_d_rdata", dDoneData[baseD], 32'h00001234);
    checkOutput("simul_if_done", 32'(ifDoneCyc[baseF] - ifRaiseCyc), 32'd7);

    $display("[TB] stores and read-back");
    baseD = dDoneCyc.size(); baseW = weCyc.size();
    applyStimulus(0, 1, 4'hF, 32'h44, 32'hDEADBEEF);
    waitIdle("store");
    checkOutput("store_we_count", 32'(weCyc.size() - baseW), 32'd1);
    checkOutput("store_we_cycle", 32'(weCyc[baseW] - dRaiseCyc), 32'd2);
    checkOutput("store_d_rdata", dDoneData[baseD], 32'h0);
    baseD = dDoneCyc.size();
    applyStimulus(0, 0, 4'h0, 32'h44, 32'h0);
    applyStimulus(0, 1, 4'h3, 32'h44, 32'h00005555);
    applyStimulus(0, 0, 4'h0, 32'h44, 32'h0);
    waitIdle("readback");
    checkOutput("readback_full", dDoneData[baseD], 32'hDEADBEEF);
    checkOutput("readback_partial", dDoneData[baseD+2], 32'hDEAD5555);

    $display("[TB] reset during store");
    baseD = dDoneCyc.size(); found = 0;
    applyStimulus(0, 1, 4'hF, 32'h48, 32'hCAFEF00D);
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (mem_en) found = 1;
    end
    checkOutput("abort_mem_en_seen", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_mem_en", 32'(mem_en), 32'd0);
    checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    waitIdle("abort");
    checkOutput("abort_no_done", 32'(dDoneCyc.size() - baseD), 32'd0);
    baseD = dDoneCyc.size();
    applyStimulus(0, 0, 4'h0, 32'h48, 32'h0);
    waitIdle("abort_readback");
    checkOutput("abort_not_committed", dDoneData[baseD], 32'h0);

    $display("[TB] data burst with fetch waiting");
    baseD = dDoneCyc.size(); baseF = ifDoneCyc.size();
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 4'h0, 32'h80 + 32'(4*i), 32'h0);
    applyStimulus(1, 0, 4'h0, 32'h10, 32'h0);
    waitIdle("burst");
    checkOutput("burst_d_count", 32'(dDoneCyc.size() - baseD), 32'd6);
    cnt = 0;
    for (int j = baseD; j < dDoneCyc.size(); j++)
      if (dDoneCyc[j] < ifDoneCyc[baseF]) cnt++;
    checkOutput("burst_fetch_position", 32'(cnt), GUARD ? 32'd4 : 32'd6);
    checkOutput("burst_last_rdata", dDoneData[baseD+5], 32'h00000105);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
